mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-port SRAM between instruction fetch and the MEM-stage data port.
// Data requests win arbitration; each access owns the SRAM for MEM_LAT cycles, then pulses ready.
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        flush,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        sram_en,
  output logic        sram_we,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  output logic        if_stall,
  output logic        mem_stall
);

  typedef enum logic [2:0] {
    IDLE,
    IF_ACC,
    DM_ACC,
    IF_DONE,
    DM_DONE
  } state_e;

  localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        flushed_q, flushed_d;
  logic        sram_en_q, sram_en_d;
  logic        sram_we_q, sram_we_d;
  logic [31:0] sram_addr_q, sram_addr_d;
  logic [31:0] sram_wdata_q, sram_wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        if_ready_q, if_ready_d;
  logic        mem_ready_q, mem_ready_d;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can leave it unassigned and infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    flushed_d    = flushed_q;
    sram_en_d    = sram_en_q;
    sram_we_d    = sram_we_q;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    if_rdata_d   = if_rdata_q;
    mem_rdata_d  = mem_rdata_q;
    if_ready_d   = 1'b0;
    mem_ready_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (mem_rd || mem_wr) begin
          state_d      = DM_ACC;
          cnt_d        = CNT_LOAD;
          sram_en_d    = 1'b1;
          sram_we_d    = mem_wr;
          sram_addr_d  = mem_addr;
          sram_wdata_d = mem_wdata;
        end else if (if_req && !flush) begin
          state_d      = IF_ACC;
          cnt_d        = CNT_LOAD;
          flushed_d    = 1'b0;
          sram_en_d    = 1'b1;
          sram_we_d    = 1'b0;
          sram_addr_d  = if_addr;
          sram_wdata_d = '0;
        end
      end

      IF_ACC: begin
        if (cnt_q == 4'd0) begin
          sram_en_d = 1'b0;
          sram_we_d = 1'b0;
          // A flush anywhere in the access still lets the SRAM cycle finish, but drops the result.
          if (flushed_q || flush) begin
            state_d = IDLE;
          end else begin
            state_d    = IF_DONE;
            if_rdata_d = sram_rdata;
            if_ready_d = 1'b1;
          end
        end else begin
          cnt_d     = cnt_q - 4'd1;
          flushed_d = flushed_q | flush;
        end
      end

      DM_ACC: begin
        if (cnt_q == 4'd0) begin
          state_d     = DM_DONE;
          sram_en_d   = 1'b0;
          sram_we_d   = 1'b0;
          mem_ready_d = 1'b1;
          if (!sram_we_q) mem_rdata_d = sram_rdata;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      IF_DONE, DM_DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      flushed_q    <= 1'b0;
      sram_en_q    <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      if_rdata_q   <= '0;
      mem_rdata_q  <= '0;
      if_ready_q   <= 1'b0;
      mem_ready_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples the pre-edge values of the others.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      flushed_q    <= flushed_d;
      sram_en_q    <= sram_en_d;
      sram_we_q    <= sram_we_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      if_rdata_q   <= if_rdata_d;
      mem_rdata_q  <= mem_rdata_d;
      if_ready_q   <= if_ready_d;
      mem_ready_q  <= mem_ready_d;
    end
  end

  assign sram_en    = sram_en_q;
  assign sram_we    = sram_we_q;
  assign sram_addr  = sram_addr_q;
  assign sram_wdata = sram_wdata_q;
  assign if_rdata   = if_rdata_q;
  assign mem_rdata  = mem_rdata_q;
  // A flush arriving in the done cycle still has to cancel the fetch pulse.
  assign if_ready   = if_ready_q & ~flush;
  assign mem_ready  = mem_ready_q;

  assign mem_stall  = (mem_rd | mem_wr) & ~mem_ready;
  assign if_stall   = (if_req & ~if_ready) | mem_stall;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed transaction table, hand-written corner
// sequences, then randomized traffic against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int unsigned MEM_LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        flush;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;
  logic        sram_en, sram_we;
  logic [31:0] sram_addr, sram_wdata, sram_rdata;
  logic        if_stall, mem_stall;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LAT(MEM_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .flush      (flush),
    .if_rdata   (if_rdata),
    .if_ready   (if_ready),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .if_stall   (if_stall),
    .mem_stall  (mem_stall)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    if_req = 1'b0;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    flush  = 1'b0;
  endtask

  // ---------------- directed transaction table ----------------
  typedef struct {
    logic        if_req, mem_rd, mem_wr;
    logic [31:0] addr, wdata, rdata;
    logic [31:0] exp_if_rdata, exp_mem_rdata;
  } txn_t;

  typedef struct {
    logic if_req, mem_rd, mem_wr;
    logic exp_if_stall, exp_mem_stall;
  } stall_vec_t;

  task automatic run_txn(input txn_t t, input string tag);
    int   n, en_cycles, bad;
    logic seen, is_if;
    is_if = t.if_req & ~(t.mem_rd | t.mem_wr);
    @(negedge clk);
    if_req     = t.if_req;
    mem_rd     = t.mem_rd;
    mem_wr     = t.mem_wr;
    if_addr    = is_if ? t.addr : ~t.addr;
    mem_addr   = is_if ? ~t.addr : t.addr;
    mem_wdata  = t.wdata;
    sram_rdata = t.rdata;
    flush      = 1'b0;
    n = 1; en_cycles = 0; bad = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk); #1;
      n++;
      if (sram_en) begin
        en_cycles++;
        if (sram_addr !== t.addr || sram_we !== t.mem_wr ||
            sram_wdata !== (is_if ? 32'h0 : t.wdata)) bad++;
      end
      if (is_if ? if_ready : mem_ready) seen = 1'b1;
      if (is_if ? mem_ready : if_ready) bad++;
    end
    check({tag, " latency"}, n, MEM_LAT + 2);
    check({tag, " sram_en cycles"}, en_cycles, MEM_LAT);
    check({tag, " sram bus errors"}, bad, 0);
    check({tag, " if_rdata"}, if_rdata, t.exp_if_rdata);
    check({tag, " mem_rdata"}, mem_rdata, t.exp_mem_rdata);
    check({tag, " stall at ready"}, is_if ? if_stall : mem_stall, 0);
    drive_idle();
    @(negedge clk); #1;
    check({tag, " single pulse"}, is_if ? if_ready : mem_ready, 0);
  endtask

  // ---------------- reference model (transaction level) ----------------
  localparam int K_IF = 0, K_RD = 1, K_WR = 2;
  int          m_edge, m_start, m_kind;
  logic        m_busy, m_post, m_flushed;
  logic        m_en, m_we, m_ifrdy, m_memrdy;
  logic [31:0] m_addr, m_wdata, m_if_rdata, m_mem_rdata;

  task automatic model_reset();
    m_edge = 0; m_start = 0; m_kind = K_IF;
    m_busy = 0; m_post = 0; m_flushed = 0;
    m_en = 0; m_we = 0; m_ifrdy = 0; m_memrdy = 0;
    m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_mem_rdata = '0;
  endtask

  // Called once per rising edge with the inputs that were presented during the ending cycle.
  task automatic model_step();
    logic ifr_n, memr_n;
    ifr_n = 1'b0; memr_n = 1'b0;
    if (m_busy) begin
      if (m_edge - m_start == int'(MEM_LAT)) begin
        m_busy = 0; m_en = 0; m_we = 0;
        if (m_kind == K_IF) begin
          if (!(m_flushed || flush)) begin
            m_if_rdata = sram_rdata; ifr_n = 1; m_post = 1;
          end
        end else begin
          if (m_kind == K_RD) m_mem_rdata = sram_rdata;
          memr_n = 1; m_post = 1;
        end
      end else if (flush) begin
        m_flushed = 1;
      end
    end else if (m_post) begin
      m_post = 0;
    end else if (mem_rd || mem_wr) begin
      m_busy = 1; m_start = m_edge; m_kind = mem_wr ? K_WR : K_RD;
      m_en = 1; m_we = mem_wr; m_addr = mem_addr; m_wdata = mem_wdata;
    end else if (if_req && !flush) begin
      m_busy = 1; m_start = m_edge; m_kind = K_IF; m_flushed = 0;
      m_en = 1; m_we = 0; m_addr = if_addr; m_wdata = '0;
    end
    m_ifrdy  = ifr_n;
    m_memrdy = memr_n;
    m_edge++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    txn_t       txns[5];
    stall_vec_t svec[8];
    int         n, en_cnt, rdy_cnt, mem_at, if_at;
    logic [31:0] first_addr, last_addr;
    logic       got_first;

    txns[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h1111_2222, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0};
    txns[1] = '{1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h3333_4444, 32'hCAFE_F00D, 32'hDEAD_BEEF, 32'hCAFE_F00D};
    txns[2] = '{1'b0, 1'b0, 1'b1, 32'h0000_0080, 32'h1234_5678, 32'hBADB_AD00, 32'hDEAD_BEEF, 32'hCAFE_F00D};
    txns[3] = '{1'b1, 1'b1, 1'b1, 32'h0000_0084, 32'hA5A5_A5A5, 32'h1111_1111, 32'hDEAD_BEEF, 32'hCAFE_F00D};
    txns[4] = '{1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h5A5A_5A5A, 32'h0000_0000, 32'h0000_0000, 32'hCAFE_F00D};

    // {if_req, mem_rd, mem_wr, exp_if_stall, exp_mem_stall} with both readies low
    svec[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    svec[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    svec[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    svec[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    svec[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    svec[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    svec[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    svec[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    rst = 1'b1;
    drive_idle();
    if_addr = 32'h0; mem_addr = 32'h0; mem_wdata = 32'h0; sram_rdata = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    #1;
    check("reset sram_en", sram_en, 0);
    check("reset sram_we", sram_we, 0);
    check("reset sram_addr", sram_addr, 0);
    check("reset sram_wdata", sram_wdata, 0);
    check("reset if_rdata", if_rdata, 0);
    check("reset mem_rdata", mem_rdata, 0);
    check("reset if_ready", if_ready, 0);
    check("reset mem_ready", mem_ready, 0);

    for (int i = 0; i < 8; i++) begin
      if_req = svec[i].if_req; mem_rd = svec[i].mem_rd; mem_wr = svec[i].mem_wr;
      #1;
      check($sformatf("stall vec%0d if_stall", i), if_stall, svec[i].exp_if_stall);
      check($sformatf("stall vec%0d mem_stall", i), mem_stall, svec[i].exp_mem_stall);
    end
    drive_idle();
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run_txn(txns[i], $sformatf("txn%0d", i));

    // Data and fetch requested together: data first, fetch granted from the following IDLE.
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h10; mem_rd = 1'b1; mem_addr = 32'h40;
    mem_wdata = 32'h77; sram_rdata = 32'h5555_AAAA;
    n = 1; mem_at = 0; if_at = 0; got_first = 0; first_addr = '0; last_addr = '0;
    while (if_at == 0 && n < 40) begin
      @(negedge clk); #1;
      n++;
      if (sram_en) begin
        if (!got_first) begin first_addr = sram_addr; got_first = 1; end
        last_addr = sram_addr;
      end
      if (mem_ready && mem_at == 0) begin mem_at = n; mem_rd = 1'b0; end
      if (if_ready) if_at = n;
    end
    check("simul mem_ready cycle", mem_at, MEM_LAT + 2);
    check("simul if_ready cycle", if_at, 2 * MEM_LAT + 4);
    check("simul first addr", first_addr, 32'h40);
    check("simul second addr", last_addr, 32'h10);
    check("simul mem_rdata", mem_rdata, 32'h5555_AAAA);
    check("simul if_rdata", if_rdata, 32'h5555_AAAA);
    drive_idle();
    @(negedge clk);

    // Flush in the second fetch access cycle: access completes, no pulse, old if_rdata kept.
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100; sram_rdata = 32'h9999_9999;
    en_cnt = 0; rdy_cnt = 0;
    for (int c = 2; c <= 12; c++) begin
      @(negedge clk);
      flush = (c == 3);
      if (c == 3) if_req = 1'b0;
      #1;
      if (sram_en) en_cnt++;
      if (if_ready) rdy_cnt++;
    end
    check("flush sram_en cycles", en_cnt, MEM_LAT);
    check("flush if_ready pulses", rdy_cnt, 0);
    check("flush if_rdata kept", if_rdata, 32'h5555_AAAA);
    drive_idle();
    run_txn('{1'b1, 1'b0, 1'b0, 32'h104, 32'h0, 32'h2468_ACE0, 32'h2468_ACE0, 32'h5555_AAAA}, "post-flush");

    // Flush during the fetch done cycle hides the pulse.
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h200; sram_rdata = 32'h1357_9BDF;
    for (int c = 2; c <= int'(MEM_LAT) + 2; c++) begin
      @(negedge clk);
      if (c == int'(MEM_LAT) + 2) flush = 1'b1;
      #1;
    end
    check("done-flush if_ready", if_ready, 0);
    check("done-flush if_stall", if_stall, 1);
    drive_idle();
    @(negedge clk); #1;
    check("done-flush next if_ready", if_ready, 0);

    // Reset in the third data access cycle aborts the access at once.
    @(negedge clk);
    mem_rd = 1'b1; mem_addr = 32'h300; sram_rdata = 32'hFEED_FACE;
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk); #1;
    end
    check("pre-reset sram_en", sram_en, 1);
    rst = 1'b1;
    #1;
    check("mid-reset sram_en", sram_en, 0);
    check("mid-reset sram_addr", sram_addr, 0);
    check("mid-reset mem_rdata", mem_rdata, 0);
    mem_rd = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    rdy_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      if (mem_ready || sram_en) rdy_cnt++;
    end
    check("post-reset activity", rdy_cnt, 0);
    run_txn('{1'b1, 1'b0, 1'b0, 32'h400, 32'h0, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 32'h0}, "post-reset");

    // Randomized traffic against the reference model.
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 600; c++) begin
      logic exp_ifr, exp_ms, exp_is;
      @(negedge clk);
      if_req     = ($urandom_range(0, 3) != 0);
      mem_rd     = ($urandom_range(0, 4) == 0);
      mem_wr     = ($urandom_range(0, 6) == 0);
      flush      = ($urandom_range(0, 7) == 0);
      if_addr    = $urandom;
      mem_addr   = $urandom;
      mem_wdata  = $urandom;
      sram_rdata = $urandom;
      #1;
      exp_ifr = m_ifrdy & ~flush;
      exp_ms  = (mem_rd | mem_wr) & ~m_memrdy;
      exp_is  = (if_req & ~exp_ifr) | exp_ms;
      check($sformatf("rnd%0d sram_en", c), sram_en, m_en);
      check($sformatf("rnd%0d sram_we", c), sram_we, m_we);
      check($sformatf("rnd%0d sram_addr", c), sram_addr, m_addr);
      check($sformatf("rnd%0d sram_wdata", c), sram_wdata, m_wdata);
      check($sformatf("rnd%0d if_rdata", c), if_rdata, m_if_rdata);
      check($sformatf("rnd%0d mem_rdata", c), mem_rdata, m_mem_rdata);
      check($sformatf("rnd%0d if_ready", c), if_ready, exp_ifr);
      check($sformatf("rnd%0d mem_ready", c), mem_ready, m_memrdy);
      check($sformatf("rnd%0d if_stall", c), if_stall, exp_is);
      check($sformatf("rnd%0d mem_stall", c), mem_stall, exp_ms);
      @(posedge clk);
      model_step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
